i2s_transmitter: RTL and testbench

- Downstream stage of the Pi serial input buffer.
- Consumes 16-bit signed samples from the buffer's `data` output and serialises them as Philips-format I2S (bclk, lrclk, sd) for the DAC.
- Pulses `ready` once per consumed sample; this drives the buffer's read-advance input.
- All logic runs on the single system clock; bclk is generated by division.

---
 rtl/i2s_transmitter_if.sv | 20 ++
 rtl/i2s_transmitter.sv | 101 ++++++++++
 tb/tb_i2s_transmitter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_transmitter_if.sv
// Sample-side handshake and I2S serial lines of the Pi-to-DAC transmitter.
// The slave modport is the transmitter; the master modport is the buffer/DAC side.
interface i2s_transmitter_if;
   logic               enable;
   logic signed [15:0] sample_in;
   logic               ready;
   logic               bclk;
   logic               lrclk;
   logic               sd;

   modport master (
      output enable, sample_in,
      input  ready, bclk, lrclk, sd
   );

   modport slave (
      input  enable, sample_in,
      output ready, bclk, lrclk, sd
   );
endinterface

// File: rtl/i2s_transmitter.sv
// Philips-format I2S serialiser: bclk divided from clk, 32-slot frame, one ready per consumed sample.
// Define I2S_TX_STEREO_EN to take separate left/right samples (ready at slots 0 and 16).
module i2s_transmitter #(
   parameter int CLK_DIV = 4
) (
   input logic              clk,
   input logic              rst,
   i2s_transmitter_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [7:0]  div_cnt;
   logic [4:0]  slot;
   logic [31:0] frame;
   logic        held_bit;
   logic        bclk_r;
   logic        lrclk_r;
   logic        sd_r;
   logic        ready_r;

   logic [4:0]  slot_nxt;
   logic [4:0]  bit_idx;
   logic        div_tc;

   assign slot_nxt = slot + 5'd1;
   // Slot k carries frame bit 32-k; negating modulo 32 yields exactly that index.
   assign bit_idx  = 5'd0 - slot_nxt;
   assign div_tc   = (div_cnt == 8'(CLK_DIV - 1));

   assign bus.bclk  = bclk_r;
   assign bus.lrclk = lrclk_r;
   assign bus.sd    = sd_r;
   assign bus.ready = ready_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= 8'd0;
         slot     <= 5'd31;
         frame    <= 32'd0;
         held_bit <= 1'b0;
         bclk_r   <= 1'b0;
         lrclk_r  <= 1'b0;
         sd_r     <= 1'b0;
         ready_r  <= 1'b0;
      end else begin
         ready_r <= 1'b0;
         case (state)
            IDLE: begin
               div_cnt <= 8'd0;
               bclk_r  <= 1'b0;
               lrclk_r <= 1'b0;
               sd_r    <= 1'b0;
               if (bus.enable) state <= RUN;
            end
            RUN: begin
               if (!div_tc) begin
                  div_cnt <= div_cnt + 8'd1;
               end else begin
                  div_cnt <= 8'd0;
                  bclk_r  <= ~bclk_r;
                  // Only the 1->0 toggle advances the frame; the rising toggle is passive.
                  if (bclk_r) begin
                     if (slot_nxt == 5'd0) begin
                        lrclk_r <= 1'b0;
                        if (!bus.enable) begin
                           state <= IDLE;
                           sd_r  <= 1'b0;
                           slot  <= 5'd31;
                        end else begin
                           slot    <= 5'd0;
                           sd_r    <= held_bit;
                           ready_r <= 1'b1;
`ifdef I2S_TX_STEREO_EN
                           frame[31:16] <= bus.sample_in;
`else
                           frame <= {bus.sample_in, bus.sample_in};
`endif
                        end
                     end else begin
                        slot    <= slot_nxt;
                        sd_r    <= frame[bit_idx];
                        lrclk_r <= slot_nxt[4];
                        // Right LSB is deferred to the next frame's slot 0.
                        if (slot_nxt == 5'd31) held_bit <= frame[0];
`ifdef I2S_TX_STEREO_EN
                        if (slot_nxt == 5'd16) begin
                           frame[15:0] <= bus.sample_in;
                           ready_r     <= 1'b1;
                        end
`endif
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: latency/spacing/stop/reset scenarios plus a bit-level sd scoreboard.
`timescale 1ns/1ps
module tb_i2s_transmitter;
   localparam int CD = 2;
`ifdef I2S_TX_STEREO_EN
   localparam int SPACING      = 32 * CD;
   localparam int TAIL_READIES = 1;
`else
   localparam int SPACING      = 64 * CD;
   localparam int TAIL_READIES = 0;
`endif

   logic clk;
   logic rst;
   i2s_transmitter_if bus();

   i2s_transmitter #(.CLK_DIV(CD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          checks;
   int          failures;
   bit          exp_q[$];
   logic [15:0] s_lat;
   logic [15:0] first_sample;
   bit          held_m;
   bit          synced;
   int          slot_m;

   // Value the DUT latched at the most recent posedge.
   task automatic capture_sample();
      forever begin
         @(posedge clk);
         s_lat = bus.sample_in;
      end
   endtask

   // Scoreboard: bits queued when a sample is consumed, popped on each bclk falling event.
   task automatic sd_monitor();
      logic bclk_prev;
      bit   e;
      bit   exp_rdy;
      bclk_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            synced = 1'b0;
            held_m = 1'b0;
            exp_q.delete();
            bclk_prev = 1'b0;
         end else begin
            if (bclk_prev === 1'b1 && bus.bclk === 1'b0) begin
               if (bus.ready === 1'b1 && (!synced || slot_m == 31)) begin
                  checks++;
                  if (bus.sd !== held_m) begin
                     failures++;
                     $display("FAIL mon_slot0_sd: got %b expected %b", bus.sd, held_m);
                  end
                  checks++;
                  if (bus.lrclk !== 1'b0 || exp_q.size() != 0) begin
                     failures++;
                     $display("FAIL mon_slot0_state: lrclk %b leftover %0d expected 0 0", bus.lrclk, exp_q.size());
                  end
                  synced = 1'b1;
                  slot_m = 0;
                  for (int i = 15; i >= 0; i--) exp_q.push_back(s_lat[i]);
`ifndef I2S_TX_STEREO_EN
                  for (int i = 15; i >= 1; i--) exp_q.push_back(s_lat[i]);
                  held_m = s_lat[0];
`endif
               end else if (synced && slot_m == 31) begin
                  checks++;
                  if (bus.sd !== 1'b0 || bus.lrclk !== 1'b0 || bus.ready !== 1'b0) begin
                     failures++;
                     $display("FAIL mon_stop: sd %b lrclk %b ready %b expected 0 0 0", bus.sd, bus.lrclk, bus.ready);
                  end
                  synced = 1'b0;
               end else if (synced) begin
                  slot_m++;
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL mon_underrun: slot %0d got empty queue expected a bit", slot_m);
                  end else begin
                     e = exp_q.pop_front();
                     if (bus.sd !== e) begin
                        failures++;
                        $display("FAIL mon_sd slot %0d: got %b expected %b", slot_m, bus.sd, e);
                     end
                  end
                  checks++;
                  if (bus.lrclk !== (slot_m >= 16)) begin
                     failures++;
                     $display("FAIL mon_lrclk slot %0d: got %b expected %b", slot_m, bus.lrclk, (slot_m >= 16));
                  end
`ifdef I2S_TX_STEREO_EN
                  exp_rdy = (slot_m == 16);
                  if (slot_m == 16) begin
                     for (int i = 15; i >= 1; i--) exp_q.push_back(s_lat[i]);
                     held_m = s_lat[0];
                  end
`else
                  exp_rdy = 1'b0;
`endif
                  checks++;
                  if (bus.ready !== exp_rdy) begin
                     failures++;
                     $display("FAIL mon_ready slot %0d: got %b expected %b", slot_m, bus.ready, exp_rdy);
                  end
               end
            end
            bclk_prev = bus.bclk;
         end
      end
   endtask

   task automatic wait_ready(input int limit, output int cnt, output logic pb);
      logic last;
      last = bus.bclk;
      pb   = 1'b0;
      cnt  = -1;
      for (int n = 1; n <= limit; n++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            cnt = n;
            pb  = last;
            break;
         end
         last = bus.bclk;
      end
   endtask

   task automatic test_reset();
      bit bad;
      repeat (3) @(negedge clk);
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.bclk, bus.lrclk, bus.sd, bus.ready} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 0000", {bus.bclk, bus.lrclk, bus.sd, bus.ready});
      end
      bus.enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if ({bus.bclk, bus.lrclk, bus.sd, bus.ready} !== 4'b0000) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL idle_quiet: got activity expected all outputs 0");
      end
   endtask

   task automatic test_first_ready();
      int   cnt;
      int   per;
      int   guard;
      logic pb;
      logic prev;
      first_sample = bus.sample_in;
      bus.enable   = 1'b1;
      wait_ready(100, cnt, pb);
      checks++;
      if (cnt != 2 * CD + 1) begin
         failures++;
         $display("FAIL first_ready_latency: got %0d expected %0d", cnt, 2 * CD + 1);
      end
      checks++;
      if (pb !== 1'b1 || bus.bclk !== 1'b0) begin
         failures++;
         $display("FAIL ready_on_fall: bclk %b->%b expected 1->0", pb, bus.bclk);
      end
      checks++;
      if (bus.sd !== 1'b0) begin
         failures++;
         $display("FAIL first_slot0_sd: got %b expected 0", bus.sd);
      end
      wait_ready(SPACING + 20, cnt, pb);
      checks++;
      if (cnt != SPACING) begin
         failures++;
         $display("FAIL ready_spacing: got %0d expected %0d", cnt, SPACING);
      end
      checks++;
      if (bus.sd !== first_sample[0]) begin
         failures++;
         $display("FAIL frame2_slot0_sd: got %b expected %b", bus.sd, first_sample[0]);
      end
      guard = 0;
      while (bus.bclk !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      per  = -1;
      prev = 1'b1;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (prev === 1'b0 && bus.bclk === 1'b1) begin
            per = n;
            break;
         end
         prev = bus.bclk;
      end
      checks++;
      if (per != 2 * CD) begin
         failures++;
         $display("FAIL bclk_period: got %0d expected %0d", per, 2 * CD);
      end
   endtask

`ifndef I2S_TX_STEREO_EN
   task automatic test_sample_change();
      int   cnt;
      logic pb;
      wait_ready(SPACING + 20, cnt, pb);
      checks++;
      if (cnt < 0) begin
         failures++;
         $display("FAIL change_sync: got timeout expected ready");
      end
      bus.sample_in = 16'h8000;
      wait_ready(SPACING + 20, cnt, pb);
      bus.sample_in = 16'h0001;
      checks++;
      if (cnt != SPACING || bus.sd !== 1'b1) begin
         failures++;
         $display("FAIL change_a5c3_tail: spacing %0d sd %b expected %0d 1", cnt, bus.sd, SPACING);
      end
      wait_ready(SPACING + 20, cnt, pb);
      checks++;
      if (cnt != SPACING || bus.sd !== 1'b0) begin
         failures++;
         $display("FAIL change_slot0: spacing %0d sd %b expected %0d 0", cnt, bus.sd, SPACING);
      end
      repeat (2 * CD) @(negedge clk);
      checks++;
      if (bus.sd !== 1'b0) begin
         failures++;
         $display("FAIL change_slot1: got %b expected 0", bus.sd);
      end
      repeat (15 * 2 * CD) @(negedge clk);
      checks++;
      if (bus.sd !== 1'b1) begin
         failures++;
         $display("FAIL change_slot16: got %b expected 1", bus.sd);
      end
      wait_ready(SPACING + 20, cnt, pb);
      checks++;
      if (cnt != SPACING - 16 * 2 * CD || bus.sd !== 1'b1) begin
         failures++;
         $display("FAIL change_next_slot0: wait %0d sd %b expected %0d 1", cnt, bus.sd, SPACING - 32 * CD);
      end
   endtask
`else
   task automatic test_stereo();
      int   cnt;
      logic pb;
      bit   aligned;
      bit   bad;
      aligned = 1'b0;
      for (int i = 0; i < 10 && !aligned; i++) begin
         wait_ready(SPACING + 20, cnt, pb);
         if (i > 0) begin
            checks++;
            if (cnt != SPACING) begin
               failures++;
               $display("FAIL stereo_spacing: got %0d expected %0d", cnt, SPACING);
            end
         end
         bus.sample_in = (bus.lrclk === 1'b1) ? 16'h8000 : 16'h0001;
         if (i >= 4 && bus.lrclk === 1'b0) aligned = 1'b1;
      end
      checks++;
      if (!aligned || bus.sd !== 1'b1) begin
         failures++;
         $display("FAIL stereo_slot0: aligned %b sd %b expected 1 1", aligned, bus.sd);
      end
      repeat (2 * CD) @(negedge clk);
      checks++;
      if (bus.sd !== 1'b1) begin
         failures++;
         $display("FAIL stereo_slot1: got %b expected 1", bus.sd);
      end
      bad = 1'b0;
      for (int k = 2; k <= 31; k++) begin
         repeat (2 * CD) @(negedge clk);
         if (bus.sd !== 1'b0) bad = 1'b1;
         if (bus.ready === 1'b1) bus.sample_in = 16'h8000;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL stereo_slots_2_31: got a 1 expected all 0");
      end
      repeat (2 * CD) @(negedge clk);
      checks++;
      if (bus.ready !== 1'b1 || bus.sd !== 1'b1) begin
         failures++;
         $display("FAIL stereo_next_slot0: ready %b sd %b expected 1 1", bus.ready, bus.sd);
      end
   endtask
`endif

   task automatic test_stop();
      int   cnt;
      int   falls;
      int   rdy;
      logic pb;
      logic prev;
      bit   got;
      bit   bad;
      got = 1'b0;
      for (int t = 0; t < 4 && !got; t++) begin
         wait_ready(SPACING + 20, cnt, pb);
         if (cnt > 0 && bus.lrclk === 1'b0) got = 1'b1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL stop_sync: got no slot-0 ready expected one");
      end
      repeat (5 * 2 * CD) @(negedge clk);
      bus.enable = 1'b0;
      falls = 0;
      rdy   = 0;
      prev  = bus.bclk;
      for (int n = 1; n < 27 * 2 * CD; n++) begin
         @(negedge clk);
         if (prev === 1'b1 && bus.bclk === 1'b0) falls++;
         if (bus.ready === 1'b1) rdy++;
         prev = bus.bclk;
      end
      checks++;
      if (falls != 26 || rdy != TAIL_READIES) begin
         failures++;
         $display("FAIL stop_tail: falls %0d readies %0d expected 26 %0d", falls, rdy, TAIL_READIES);
      end
      bad = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if ({bus.bclk, bus.lrclk, bus.sd, bus.ready} !== 4'b0000) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL stop_idle: got activity expected all outputs 0");
      end
      bus.enable = 1'b1;
      wait_ready(100, cnt, pb);
      checks++;
      if (cnt != 2 * CD + 1) begin
         failures++;
         $display("FAIL restart_latency: got %0d expected %0d", cnt, 2 * CD + 1);
      end
   endtask

   task automatic test_reset_mid();
      int   cnt;
      logic pb;
      repeat (20 * 2 * CD + CD) @(negedge clk);
      checks++;
      if (bus.lrclk !== 1'b1 || bus.bclk !== 1'b1) begin
         failures++;
         $display("FAIL slot20_running: lrclk %b bclk %b expected 1 1", bus.lrclk, bus.bclk);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.bclk, bus.lrclk, bus.sd, bus.ready} !== 4'b0000) begin
         failures++;
         $display("FAIL async_reset: got %b expected 0000", {bus.bclk, bus.lrclk, bus.sd, bus.ready});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(100, cnt, pb);
      checks++;
      if (cnt != 2 * CD + 1) begin
         failures++;
         $display("FAIL post_reset_latency: got %0d expected %0d", cnt, 2 * CD + 1);
      end
      repeat (SPACING + 2 * CD) @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      bus.enable = 1'b0;
`ifdef I2S_TX_STEREO_EN
      bus.sample_in = 16'h8000;
`else
      bus.sample_in = 16'hA5C3;
`endif
      held_m = 1'b0;
      synced = 1'b0;
      slot_m = 31;
      s_lat  = 16'h0000;
      fork
         capture_sample();
         sd_monitor();
      join_none
      test_reset();
      test_first_ready();
`ifdef I2S_TX_STEREO_EN
      test_stereo();
`else
      test_sample_change();
`endif
      test_stop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
